// File: rtl/ascon_arbiter.sv
// ascon_arbiter
// Two-requester round-robin arbiter and job sequencer for a single Ascon core.
// One requester owns the core per job. The owner's key, nonce and data words
// are muxed onto the core inputs. The arbiter pulses the core start, returns
// the core's cipher-valid and done strobes to the owner, and aborts a stalled
// job through the core's system-enable input.
//
// Ports:
//   clock, reset_n            system clock, asynchronous active-low reset
//   i_req[1:0]                per-requester job request (level)
//   i_data_0/1, i_data_valid  requester data words and their valid bits
//   i_key_0/1, i_nonce_0/1    requester keys and nonces
//   i_core_valid_cipher       cipher-valid strobe from the core
//   i_core_done               end-of-job strobe from the core
//   o_grant[1:0]              registered one-hot owner
//   o_busy                    arbiter is not idle
//   o_core_sys_enable         core system enable (low only while aborting)
//   o_core_start              one-cycle job start pulse to the core
//   o_core_data_valid         owner's data valid, gated to the run phase
//   o_core_data/key/nonce     owner's data, key and nonce (zero with no owner)
//   o_valid_cipher[1:0]       cipher-valid routed to the owner
//   o_done[1:0]               job-done pulse routed to the owner
//   o_error[1:0]              watchdog-timeout pulse routed to the owner
module ascon_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int KEY_WIDTH  = 128,
  parameter int TIMEOUT    = 1023
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [1:0]            i_req,
  input  logic [DATA_WIDTH-1:0] i_data_0,
  input  logic [DATA_WIDTH-1:0] i_data_1,
  input  logic [1:0]            i_data_valid,
  input  logic [KEY_WIDTH-1:0]  i_key_0,
  input  logic [KEY_WIDTH-1:0]  i_key_1,
  input  logic [KEY_WIDTH-1:0]  i_nonce_0,
  input  logic [KEY_WIDTH-1:0]  i_nonce_1,
  input  logic                  i_core_valid_cipher,
  input  logic                  i_core_done,
  output logic [1:0]            o_grant,
  output logic                  o_busy,
  output logic                  o_core_sys_enable,
  output logic                  o_core_start,
  output logic                  o_core_data_valid,
  output logic [DATA_WIDTH-1:0] o_core_data,
  output logic [KEY_WIDTH-1:0]  o_core_key,
  output logic [KEY_WIDTH-1:0]  o_core_nonce,
  output logic [1:0]            o_valid_cipher,
  output logic [1:0]            o_done,
  output logic [1:0]            o_error
);

  localparam int CW = $clog2(TIMEOUT + 1);

  // The watchdog is cleared in GRANT, so it holds k-1 in the k-th RUN cycle;
  // matching TIMEOUT-1 makes ABORT follow exactly TIMEOUT RUN cycles.
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] WD_ONE  = CW'(1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_GRANT   = 3'd1;
  localparam logic [2:0] S_RUN     = 3'd2;
  localparam logic [2:0] S_RELEASE = 3'd3;
  localparam logic [2:0] S_ABORT   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic          ptr_q, ptr_d;
  logic [CW-1:0] wdog_q, wdog_d;
  logic          tmo_q, tmo_d;
  logic          in_run;
  logic          owner_req;

  assign in_run    = (state_q == S_RUN);
  assign owner_req = |(i_req & grant_q);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    wdog_d  = wdog_q;
    tmo_d   = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (i_req != 2'b00) begin
          state_d = S_GRANT;
          if (i_req == 2'b11) grant_d = ptr_q ? 2'b10 : 2'b01;
          else                grant_d = i_req;
        end
      end
      S_GRANT: begin
        wdog_d  = '0;
        tmo_d   = 1'b0;
        state_d = S_RUN;
      end
      S_RUN: begin
        wdog_d = wdog_q + WD_ONE;
        // Done wins over a dropped request, which wins over the timeout.
        if (i_core_done) begin
          state_d = S_RELEASE;
        end else if (!owner_req) begin
          state_d = S_ABORT;
          tmo_d   = 1'b0;
        end else if (wdog_q == WD_LAST) begin
          state_d = S_ABORT;
          tmo_d   = 1'b1;
        end
      end
      S_RELEASE, S_ABORT: begin
        // Hand priority to the other requester for the next contended job.
        ptr_d   = grant_q[0];
        grant_d = 2'b00;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      grant_q <= 2'b00;
      ptr_q   <= 1'b0;
      wdog_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      wdog_q  <= wdog_d;
      tmo_q   <= tmo_d;
    end
  end

  // Owner operand mux; an idle arbiter presents all-zero operands.
  always_comb begin
    o_core_data  = '0;
    o_core_key   = '0;
    o_core_nonce = '0;
    if (grant_q[0]) begin
      o_core_data  = i_data_0;
      o_core_key   = i_key_0;
      o_core_nonce = i_nonce_0;
    end else if (grant_q[1]) begin
      o_core_data  = i_data_1;
      o_core_key   = i_key_1;
      o_core_nonce = i_nonce_1;
    end
  end

  assign o_grant           = grant_q;
  assign o_busy            = (state_q != S_IDLE);
  assign o_core_sys_enable = (state_q != S_ABORT);
  assign o_core_start      = (state_q == S_GRANT);
  assign o_core_data_valid = in_run & |(i_data_valid & grant_q);
  assign o_valid_cipher    = (in_run && i_core_valid_cipher) ? grant_q : 2'b00;
  assign o_done            = (in_run && i_core_done) ? grant_q : 2'b00;
  assign o_error           = (state_q == S_ABORT && tmo_q) ? grant_q : 2'b00;

endmodule
